// File: rtl/tribus4a_pkg.sv
// Shared widths, command encodings and controller states for the tribus4a master.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package tribus4a_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 128;
    localparam int NBANK  = 4;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_READ  = 2'b01,
        OP_FILL  = 2'b10,
        OP_NOP   = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ADDR,
        ST_RD_DATA,
        ST_FILL
    } state_e;

    // Bank number to write-enable vector (bank 0 -> WREN1).
    function automatic logic [NBANK-1:0] bank_onehot(input logic [1:0] bank);
        return 4'b0001 << bank;
    endfunction

endpackage

// File: rtl/tribus4a_fill_cnt.sv
// Fill address counter: steps 0..DEPTH-1 and wraps, with clear and terminal count.
// Latency: count updates one edge after clr/en; tc is combinational from the count.
// Backpressure: none; advances whenever en is high.
module tribus4a_fill_cnt
    import tribus4a_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    output logic [ADDR_W-1:0] cnt,
    output logic              tc
);

    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // Clear has priority over counting; natural wrap from DEPTH-1 back to 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + ADDR_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
    assign tc  = (cnt_q == ADDR_W'(DEPTH - 1));

endmodule

// File: rtl/tribus4a_master.sv
// Command master for four banks sharing A/D/readback buses: WRITE, READ, FILL, NOP.
// Latency: write pulse 1 cycle after accept; read response 2 edges after the accept edge; fill 128 cycles.
// Backpressure: REQ_READY high only in IDLE; requests while busy are not accepted.
module tribus4a_master
    import tribus4a_pkg::*;
(
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [1:0]        REQ_OP,
    input  logic [1:0]        REQ_BANK,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic [DATA_W-1:0] REQ_DATA,
    output logic              RSP_VALID,
    output logic [DATA_W-1:0] RSP_DATA,
    output logic              BUSY,
    output logic [ADDR_W-1:0] A,
    output logic [DATA_W-1:0] D,
    output logic              WREN1,
    output logic              WREN2,
    output logic              WREN3,
    output logic              WREN4,
    output logic [1:0]        ENA,
    input  logic [DATA_W-1:0] QIN
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] d_q, d_d;
    logic [NBANK-1:0]  wren_q, wren_d;
    logic [1:0]        ena_q, ena_d;
    logic              rsp_vld_q, rsp_vld_d;
    logic [DATA_W-1:0] rsp_dat_q, rsp_dat_d;

    logic              cnt_clr;
    logic              cnt_en;
    logic [ADDR_W-1:0] fill_cnt;
    logic              fill_tc;
    logic [ADDR_W-1:0] fill_cnt_nxt;

    assign fill_cnt_nxt = fill_cnt + ADDR_W'(1);

    tribus4a_fill_cnt u_fill_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cnt   (fill_cnt),
        .tc    (fill_tc)
    );

    // Next state and next values of every registered bus output.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        d_d       = d_q;
        wren_d    = '0;
        ena_d     = ena_q;
        rsp_vld_d = 1'b0;
        rsp_dat_d = rsp_dat_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (REQ_VALID) begin
                    case (REQ_OP)
                        OP_WRITE: begin
                            a_d     = REQ_ADDR;
                            d_d     = REQ_DATA;
                            wren_d  = bank_onehot(REQ_BANK);
                            state_d = ST_WR;
                        end
                        OP_READ: begin
                            a_d     = REQ_ADDR;
                            ena_d   = REQ_BANK;
                            state_d = ST_RD_ADDR;
                        end
                        OP_FILL: begin
                            // First fill word goes out at address 0 with the seed itself.
                            a_d     = '0;
                            d_d     = REQ_DATA;
                            wren_d  = bank_onehot(REQ_BANK);
                            cnt_clr = 1'b1;
                            state_d = ST_FILL;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WR: begin
                state_d = ST_IDLE;
            end
            ST_RD_ADDR: begin
                state_d = ST_RD_DATA;
            end
            ST_RD_DATA: begin
                rsp_vld_d = 1'b1;
                rsp_dat_d = QIN;
                state_d   = ST_IDLE;
            end
            ST_FILL: begin
                // Counter always advances so it wraps back to 0 on the exit edge.
                cnt_en = 1'b1;
                if (fill_tc) begin
                    state_d = ST_IDLE;
                end else begin
                    // A tracks the counter; D = seed + count, kept incrementally.
                    a_d    = fill_cnt_nxt;
                    d_d    = d_q + DATA_W'(1);
                    wren_d = wren_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            d_q       <= '0;
            wren_q    <= '0;
            ena_q     <= '0;
            rsp_vld_q <= 1'b0;
            rsp_dat_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            d_q       <= d_d;
            wren_q    <= wren_d;
            ena_q     <= ena_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_dat_q <= rsp_dat_d;
        end
    end

    assign REQ_READY = (state_q == ST_IDLE);
    assign BUSY      = (state_q != ST_IDLE);
    assign A         = a_q;
    assign D         = d_q;
    assign WREN1     = wren_q[0];
    assign WREN2     = wren_q[1];
    assign WREN3     = wren_q[2];
    assign WREN4     = wren_q[3];
    assign ENA       = ena_q;
    assign RSP_VALID = rsp_vld_q;
    assign RSP_DATA  = rsp_dat_q;

endmodule

// File: tb/tb_tribus4a_master.sv
// Self-checking bench for tribus4a_master with a four-bank memory on the shared buses.
// Latency: read response expected on the third rising edge counting the accept edge as the first.
// Backpressure: commands are only presented as accepted when REQ_READY is high.
module tb_tribus4a_master;
    import tribus4a_pkg::*;

    logic       CLK = 1'b0;
    logic       RST_N;
    logic       REQ_VALID;
    logic       REQ_READY;
    logic [1:0] REQ_OP;
    logic [1:0] REQ_BANK;
    logic [6:0] REQ_ADDR;
    logic [7:0] REQ_DATA;
    logic       RSP_VALID;
    logic [7:0] RSP_DATA;
    logic       BUSY;
    logic [6:0] A;
    logic [7:0] D;
    logic       WREN1, WREN2, WREN3, WREN4;
    logic [1:0] ENA;
    logic [7:0] QIN;

    always #5 CLK = ~CLK;

    tribus4a_master dut (
        .CLK(CLK), .RST_N(RST_N),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_BANK(REQ_BANK), .REQ_ADDR(REQ_ADDR), .REQ_DATA(REQ_DATA),
        .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .BUSY(BUSY),
        .A(A), .D(D), .WREN1(WREN1), .WREN2(WREN2), .WREN3(WREN3), .WREN4(WREN4),
        .ENA(ENA), .QIN(QIN)
    );

    // The four banks: synchronous write, combinational readback selected by ENA.
    logic [7:0] bank_mem [4][128];
    always @(posedge CLK) begin
        if (WREN1) bank_mem[0][A] <= D;
        if (WREN2) bank_mem[1][A] <= D;
        if (WREN3) bank_mem[2][A] <= D;
        if (WREN4) bank_mem[3][A] <= D;
    end
    assign QIN = bank_mem[ENA][A];

    wire [3:0] wren = {WREN4, WREN3, WREN2, WREN1};

    // Reference model: what each bank location should hold, plus expected held bus values.
    logic [7:0] ref_mem [4][128];
    bit         known   [4][128];
    logic [6:0] exp_a;
    logic [7:0] exp_d;
    logic [1:0] exp_ena;

    int n_checks = 0;
    int n_fail   = 0;

    // Advance one cycle and check the write enables are one-hot or zero.
    task automatic tick();
        @(posedge CLK);
        #1;
        n_checks++;
        if ($countones(wren) > 1) begin
            n_fail++;
            $display("FAIL wren_onehot: wren=%b required one-hot or zero", wren);
        end
    endtask

    task automatic drive(input bit v, input logic [1:0] op, input logic [1:0] b,
                         input logic [6:0] ad, input logic [7:0] dt);
        REQ_VALID = v; REQ_OP = op; REQ_BANK = b; REQ_ADDR = ad; REQ_DATA = dt;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        drive(1'b0, OP_NOP, 2'd0, 7'd0, 8'd0);
        repeat (3) @(posedge CLK);
        #1;
        n_checks++; if (REQ_READY !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b required 1", REQ_READY); end
        n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b required 0", BUSY); end
        n_checks++; if (A !== 7'h00 || D !== 8'h00) begin n_fail++; $display("FAIL rst_ad: A=%h D=%h required 00/00", A, D); end
        n_checks++; if (wren !== 4'b0000 || ENA !== 2'b00) begin n_fail++; $display("FAIL rst_wren_ena: wren=%b ENA=%b required 0000/00", wren, ENA); end
        n_checks++; if (RSP_VALID !== 1'b0 || RSP_DATA !== 8'h00) begin n_fail++; $display("FAIL rst_rsp: v=%b d=%h required 0/00", RSP_VALID, RSP_DATA); end
        RST_N = 1'b1;
        exp_a = 7'h00; exp_d = 8'h00; exp_ena = 2'b00;
        tick();
        n_checks++; if (REQ_READY !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b required 1", REQ_READY); end
    endtask

    task automatic test_write(input logic [1:0] b, input logic [6:0] ad, input logic [7:0] dt);
        logic [3:0] exp_w;
        exp_w = 4'b0001 << b;
        n_checks++; if (REQ_READY !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b required 1", REQ_READY); end
        drive(1'b1, OP_WRITE, b, ad, dt);
        tick();
        drive(1'b0, OP_NOP, 2'd0, 7'd0, 8'd0);
        n_checks++; if (wren !== exp_w) begin n_fail++; $display("FAIL wr_wren: got %b required %b", wren, exp_w); end
        n_checks++; if (A !== ad || D !== dt) begin n_fail++; $display("FAIL wr_bus: A=%h D=%h required %h/%h", A, D, ad, dt); end
        n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b required 1", BUSY); end
        ref_mem[b][ad] = dt; known[b][ad] = 1'b1;
        exp_a = ad; exp_d = dt;
        tick();
        n_checks++; if (wren !== 4'b0000 || BUSY !== 1'b0) begin n_fail++; $display("FAIL wr_end: wren=%b busy=%b required 0000/0", wren, BUSY); end
        n_checks++; if (A !== exp_a || D !== exp_d) begin n_fail++; $display("FAIL wr_hold: A=%h D=%h required %h/%h", A, D, exp_a, exp_d); end
    endtask

    task automatic test_read(input logic [1:0] b, input logic [6:0] ad);
        logic [7:0] exp_q;
        exp_q = ref_mem[b][ad];
        drive(1'b1, OP_READ, b, ad, 8'h00);
        tick();
        drive(1'b0, OP_NOP, 2'd0, 7'd0, 8'd0);
        n_checks++; if (ENA !== b || A !== ad) begin n_fail++; $display("FAIL rd_addr: ENA=%b A=%h required %b/%h", ENA, A, b, ad); end
        n_checks++; if (wren !== 4'b0000 || RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL rd_addr_quiet: wren=%b rv=%b required 0000/0", wren, RSP_VALID); end
        exp_a = ad; exp_ena = b;
        tick();
        n_checks++; if (RSP_VALID !== 1'b0 || BUSY !== 1'b1) begin n_fail++; $display("FAIL rd_data_phase: rv=%b busy=%b required 0/1", RSP_VALID, BUSY); end
        tick();
        n_checks++; if (RSP_VALID !== 1'b1) begin n_fail++; $display("FAIL rd_latency: rv=%b required 1", RSP_VALID); end
        n_checks++; if (RSP_DATA !== exp_q) begin n_fail++; $display("FAIL rd_data: got %h required %h", RSP_DATA, exp_q); end
        n_checks++; if (REQ_READY !== 1'b1) begin n_fail++; $display("FAIL rd_rsp_ready: got %b required 1", REQ_READY); end
        tick();
        n_checks++; if (RSP_VALID !== 1'b0 || RSP_DATA !== exp_q) begin n_fail++; $display("FAIL rd_pulse_hold: rv=%b d=%h required 0/%h", RSP_VALID, RSP_DATA, exp_q); end
        n_checks++; if (ENA !== exp_ena) begin n_fail++; $display("FAIL rd_ena_hold: got %b required %b", ENA, exp_ena); end
    endtask

    task automatic test_fill(input logic [1:0] b, input logic [7:0] seed);
        logic [3:0] exp_w;
        logic [7:0] exp_v;
        exp_w = 4'b0001 << b;
        drive(1'b1, OP_FILL, b, 7'h55, seed);
        tick();
        drive(1'b0, OP_NOP, 2'd0, 7'd0, 8'd0);
        for (int c = 0; c < 128; c++) begin
            exp_v = 8'((int'(seed) + c) % 256);
            n_checks++; if (wren !== exp_w || BUSY !== 1'b1) begin n_fail++; $display("FAIL fill_wren c=%0d: wren=%b busy=%b required %b/1", c, wren, BUSY, exp_w); end
            n_checks++; if (A !== 7'(c) || D !== exp_v) begin n_fail++; $display("FAIL fill_bus c=%0d: A=%h D=%h required %h/%h", c, A, D, 7'(c), exp_v); end
            ref_mem[b][c] = exp_v; known[b][c] = 1'b1;
            tick();
        end
        exp_a = 7'h7F; exp_d = 8'((int'(seed) + 127) % 256);
        n_checks++; if (BUSY !== 1'b0 || wren !== 4'b0000) begin n_fail++; $display("FAIL fill_end: busy=%b wren=%b required 0/0000", BUSY, wren); end
        n_checks++; if (A !== exp_a || D !== exp_d) begin n_fail++; $display("FAIL fill_hold: A=%h D=%h required %h/%h", A, D, exp_a, exp_d); end
    endtask

    task automatic test_nop();
        drive(1'b1, OP_NOP, 2'($urandom_range(0, 3)), 7'($urandom_range(0, 127)), 8'($urandom_range(0, 255)));
        tick();
        drive(1'b0, OP_NOP, 2'd0, 7'd0, 8'd0);
        n_checks++; if (BUSY !== 1'b0 || wren !== 4'b0000 || RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL nop_quiet: busy=%b wren=%b rv=%b required 0/0000/0", BUSY, wren, RSP_VALID); end
        n_checks++; if (A !== exp_a || D !== exp_d || ENA !== exp_ena) begin n_fail++; $display("FAIL nop_hold: A=%h D=%h ENA=%b required %h/%h/%b", A, D, ENA, exp_a, exp_d, exp_ena); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] b, b3;
        logic [6:0] ad, ad3;
        logic [7:0] d1, d2, d3;
        b = 2'($urandom_range(0, 3)); ad = 7'($urandom_range(0, 127));
        d1 = 8'($urandom_range(0, 255)); d2 = ~d1;
        b3 = 2'($urandom_range(0, 3)); ad3 = 7'($urandom_range(0, 127)); d3 = 8'($urandom_range(0, 255));
        drive(1'b1, OP_WRITE, b, ad, d1);
        tick();
        n_checks++; if (D !== d1 || BUSY !== 1'b1) begin n_fail++; $display("FAIL b2b_w1: D=%h busy=%b required %h/1", D, BUSY, d1); end
        drive(1'b1, OP_WRITE, b, ad, d2);
        tick();
        n_checks++; if (BUSY !== 1'b0 || wren !== 4'b0000 || D !== d1) begin n_fail++; $display("FAIL b2b_gap: busy=%b wren=%b D=%h required 0/0000/%h", BUSY, wren, D, d1); end
        tick();
        n_checks++; if (wren !== (4'b0001 << b) || D !== d2) begin n_fail++; $display("FAIL b2b_w2: wren=%b D=%h required %b/%h", wren, D, 4'b0001 << b, d2); end
        drive(1'b1, OP_READ, b, ad, 8'h00);
        tick();
        n_checks++; if (ENA !== exp_ena || BUSY !== 1'b0) begin n_fail++; $display("FAIL b2b_no_accept: ENA=%b busy=%b required %b/0", ENA, BUSY, exp_ena); end
        tick();
        n_checks++; if (ENA !== b || BUSY !== 1'b1) begin n_fail++; $display("FAIL b2b_rd_accept: ENA=%b busy=%b required %b/1", ENA, BUSY, b); end
        drive(1'b1, OP_WRITE, b3, ad3, d3);
        tick();
        n_checks++; if (wren !== 4'b0000 || RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_ignore: wren=%b rv=%b required 0000/0", wren, RSP_VALID); end
        tick();
        n_checks++; if (RSP_VALID !== 1'b1 || RSP_DATA !== d2) begin n_fail++; $display("FAIL b2b_rd_data: rv=%b d=%h required 1/%h", RSP_VALID, RSP_DATA, d2); end
        tick();
        drive(1'b0, OP_NOP, 2'd0, 7'd0, 8'd0);
        n_checks++; if (wren !== (4'b0001 << b3) || A !== ad3 || D !== d3) begin n_fail++; $display("FAIL b2b_same_edge_accept: wren=%b A=%h D=%h required %b/%h/%h", wren, A, D, 4'b0001 << b3, ad3, d3); end
        tick();
        ref_mem[b][ad] = d2; known[b][ad] = 1'b1;
        ref_mem[b3][ad3] = d3; known[b3][ad3] = 1'b1;
        exp_a = ad3; exp_d = d3; exp_ena = b;
    endtask

    task automatic test_random();
        logic [1:0] b;
        logic [6:0] ad;
        for (int i = 0; i < 30; i++) begin
            b = 2'($urandom_range(0, 3)); ad = 7'($urandom_range(0, 127));
            case ($urandom_range(0, 2))
                0: test_write(b, ad, 8'($urandom_range(0, 255)));
                1: begin
                    if (!known[b][ad]) b = 2'd3;
                    test_read(b, ad);
                end
                default: test_nop();
            endcase
        end
    endtask

    task automatic test_reset_mid_read();
        drive(1'b1, OP_READ, 2'd3, 7'($urandom_range(0, 127)), 8'h00);
        tick();
        drive(1'b0, OP_NOP, 2'd0, 7'd0, 8'd0);
        tick();
        RST_N = 1'b0;
        #1;
        n_checks++; if (BUSY !== 1'b0 || ENA !== 2'b00 || A !== 7'h00) begin n_fail++; $display("FAIL rdrst_outputs: busy=%b ENA=%b A=%h required 0/00/00", BUSY, ENA, A); end
        tick();
        RST_N = 1'b1;
        exp_a = 7'h00; exp_d = 8'h00; exp_ena = 2'b00;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++; if (RSP_VALID !== 1'b0) begin n_fail++; $display("FAIL rdrst_no_rsp k=%0d: rv=%b required 0", k, RSP_VALID); end
        end
    endtask

    task automatic test_reset_mid_fill();
        logic [7:0] seed;
        seed = 8'($urandom_range(0, 255));
        drive(1'b1, OP_FILL, 2'd0, 7'h00, seed);
        tick();
        drive(1'b0, OP_NOP, 2'd0, 7'd0, 8'd0);
        repeat (40) tick();
        n_checks++; if (A !== 7'd40 || WREN1 !== 1'b1) begin n_fail++; $display("FAIL fillrst_pos: A=%h wren1=%b required 28/1", A, WREN1); end
        RST_N = 1'b0;
        #1;
        n_checks++; if (wren !== 4'b0000 || BUSY !== 1'b0 || REQ_READY !== 1'b1) begin n_fail++; $display("FAIL fillrst_drop: wren=%b busy=%b rdy=%b required 0000/0/1", wren, BUSY, REQ_READY); end
        n_checks++; if (A !== 7'h00 || D !== 8'h00 || ENA !== 2'b00 || RSP_DATA !== 8'h00) begin n_fail++; $display("FAIL fillrst_vals: A=%h D=%h ENA=%b rd=%h required 00/00/00/00", A, D, ENA, RSP_DATA); end
        tick();
        n_checks++; if (wren !== 4'b0000) begin n_fail++; $display("FAIL fillrst_held: wren=%b required 0000", wren); end
        RST_N = 1'b1;
        for (int c = 0; c < 40; c++) begin
            ref_mem[0][c] = 8'((int'(seed) + c) % 256); known[0][c] = 1'b1;
        end
        exp_a = 7'h00; exp_d = 8'h00; exp_ena = 2'b00;
        test_nop();
        test_read(2'd0, 7'd39);
    endtask

    initial begin
        test_reset();
        test_write(2'd2, 7'h15, 8'hA5);
        test_write(2'd1, 7'h15, 8'h3C);
        test_read(2'd1, 7'h15);
        test_fill(2'd3, 8'hF0);
        test_back_to_back();
        test_random();
        test_reset_mid_read();
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
